// File: rtl/random_delay_timer_if.sv
// Control/status bundle between the reaction-timer FSM and the random delay timer.
// The master side requests waits; the slave side (the timer) reports progress.
interface random_delay_timer_if;
    logic        start;
    logic        abort;
    logic [15:0] rnd;
    logic        busy;
    logic        expired;
    logic [15:0] remaining;

    modport master (
        output start,
        output abort,
        output rnd,
        input  busy,
        input  expired,
        input  remaining
    );

    modport slave (
        input  start,
        input  abort,
        input  rnd,
        output busy,
        output expired,
        output remaining
    );
endinterface

// File: rtl/random_delay_timer.sv
// Turns a clamped random value into a wait of that many millisecond ticks,
// ending with a one-cycle expiry pulse.
module random_delay_timer #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned MIN_DLY  = 2000,
    parameter int unsigned MAX_DLY  = 15000
) (
    input  logic                 clk,
    input  logic                 areset_n,
    random_delay_timer_if.slave  bus
);

    localparam int unsigned PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TickLast = PW'(TICK_DIV - 1);
    localparam logic [15:0]   MinDly   = 16'(MIN_DLY);
    localparam logic [15:0]   MaxDly   = 16'(MAX_DLY);

    typedef enum logic [0:0] {StIdle, StCount} state_e;

    state_e        state_q;
    logic [PW-1:0] presc_q;
    logic [15:0]   remaining_q;
    logic          busy_q;
    logic          expired_q;
    logic [15:0]   rnd_clamped;

    always_comb begin
        rnd_clamped = bus.rnd;
        if (bus.rnd < MinDly) begin
            rnd_clamped = MinDly;
        end else if (bus.rnd > MaxDly) begin
            rnd_clamped = MaxDly;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start && !bus.abort) begin
                        remaining_q <= rnd_clamped;
                        presc_q     <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= StCount;
                    end
                end
                StCount: begin
                    // abort wins even over the final tick, so no pulse escapes
                    if (bus.abort) begin
                        remaining_q <= '0;
                        presc_q     <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end else if (presc_q == TickLast) begin
                        presc_q <= '0;
                        if (remaining_q == 16'd1) begin
                            remaining_q <= '0;
                            expired_q   <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            remaining_q <= remaining_q - 16'd1;
                        end
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.expired   = expired_q;
    assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_random_delay_timer.sv
// Bench for random_delay_timer with a 4-cycle tick: directed waits, clamp table,
// abort/reset corner cases and randomized start/abort traffic against a model.
module tb_random_delay_timer;

    localparam int unsigned TD = 4;

    logic clk = 1'b0;
    logic areset_n;

    random_delay_timer_if bus ();

    random_delay_timer #(
        .TICK_DIV (TD),
        .MIN_DLY  (2000),
        .MAX_DLY  (15000)
    ) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a wait is an active flag, its clamped length and edges elapsed.
    bit m_active;
    int m_len;
    int m_n;
    bit m_pulse;

    typedef struct {
        logic [15:0] rnd;
        logic [15:0] exp_rem;
    } vec_t;

    vec_t vecs[9];

    function automatic int clamp(int r);
        if (r < 2000) return 2000;
        if (r > 15000) return 15000;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_active = 1'b0;
        m_len    = 0;
        m_n      = 0;
        m_pulse  = 1'b0;
    endtask

    task automatic model_edge();
        m_pulse = 1'b0;
        if (!m_active) begin
            if (bus.start && !bus.abort) begin
                m_active = 1'b1;
                m_len    = clamp(int'(bus.rnd));
                m_n      = 0;
            end
        end else if (bus.abort) begin
            m_active = 1'b0;
        end else begin
            m_n++;
            if (m_n == m_len * TD) begin
                m_active = 1'b0;
                m_pulse  = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        chk("model_busy", bus.busy, m_active);
        chk("model_expired", bus.expired, m_pulse);
        chk("model_remaining", bus.remaining, m_active ? (m_len - m_n / TD) : 0);
    endtask

    // One clock edge: inputs as currently driven are sampled, outputs checked 1 later.
    task automatic step();
        @(posedge clk);
        #1;
        if (areset_n) model_edge();
        check_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int seen;

        vecs[0] = '{16'd100,   16'd2000};
        vecs[1] = '{16'd40000, 16'd15000};
        vecs[2] = '{16'd15000, 16'd15000};
        vecs[3] = '{16'd2000,  16'd2000};
        vecs[4] = '{16'd1999,  16'd2000};
        vecs[5] = '{16'd15001, 16'd15000};
        vecs[6] = '{16'd0,     16'd2000};
        vecs[7] = '{16'd65535, 16'd15000};
        vecs[8] = '{16'd7777,  16'd7777};

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.rnd   = '0;
        areset_n  = 1'b0;
        model_clear();
        #2;
        chk("reset_busy", bus.busy, 0);
        chk("reset_expired", bus.expired, 0);
        chk("reset_remaining", bus.remaining, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset_n = 1'b1;
        repeat (3) step();

        // Minimum wait: expiry exactly 2000*TD edges after the capture edge.
        bus.rnd   = 16'd2000;
        bus.start = 1'b1;
        step();
        chk("t1_busy", bus.busy, 1);
        chk("t1_remaining", bus.remaining, 2000);
        bus.start = 1'b0;
        bus.rnd   = 16'h1234;
        got = 0;
        for (int i = 1; i <= 8010; i++) begin
            step();
            if (bus.expired) begin
                got = i;
                break;
            end
        end
        chk("t1_expiry_cycle", got, 8000);
        step();
        chk("t1_pulse_width", bus.expired, 0);
        chk("t1_busy_after", bus.busy, 0);

        for (int i = 0; i < 9; i++) begin
            bus.rnd   = vecs[i].rnd;
            bus.start = 1'b1;
            step();
            chk("clamp_remaining", bus.remaining, vecs[i].exp_rem);
            bus.start = 1'b0;
            bus.abort = 1'b1;
            step();
            chk("clamp_abort_busy", bus.busy, 0);
            bus.abort = 1'b0;
            step();
        end

        // Abort midway.
        bus.rnd   = 16'd2000;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (2000) step();
        chk("t3_rem_before", bus.remaining, 1500);
        bus.abort = 1'b1;
        step();
        chk("t3_busy", bus.busy, 0);
        chk("t3_remaining", bus.remaining, 0);
        bus.abort = 1'b0;
        seen = 0;
        repeat (50) begin
            step();
            if (bus.expired) seen = 1;
        end
        chk("t3_no_expire", seen, 0);

        // Abort coincident with the final tick.
        bus.rnd   = 16'd2000;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (7999) step();
        chk("t4_rem_before", bus.remaining, 1);
        bus.abort = 1'b1;
        step();
        chk("t4_expired", bus.expired, 0);
        chk("t4_busy", bus.busy, 0);
        bus.abort = 1'b0;
        step();
        chk("t4_expired_after", bus.expired, 0);

        // Start held through a wait with rnd churning; then immediate re-capture.
        bus.rnd   = 16'd3000;
        bus.start = 1'b1;
        step();
        got = 0;
        for (int i = 1; i <= 12010; i++) begin
            bus.rnd = 16'($urandom);
            step();
            if (bus.expired) begin
                got = i;
                break;
            end
        end
        chk("t5_expiry_cycle", got, 12000);
        bus.rnd = 16'd5000;
        step();
        chk("t5_recapture_busy", bus.busy, 1);
        chk("t5_recapture_rem", bus.remaining, 5000);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;

        // Asynchronous reset mid-count.
        bus.rnd   = 16'd2500;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (1000) step();
        areset_n = 1'b0;
        #1;
        model_clear();
        chk("t6_busy", bus.busy, 0);
        chk("t6_expired", bus.expired, 0);
        chk("t6_remaining", bus.remaining, 0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        repeat (20) step();
        chk("t6_idle", bus.busy, 0);

        // Random traffic.
        for (int seg = 0; seg < 4; seg++) begin
            repeat (2500) begin
                bus.rnd   = 16'($urandom);
                bus.start = ($urandom_range(0, 3) == 0);
                bus.abort = ($urandom_range(0, 999) == 0);
                step();
            end
            bus.start = 1'b0;
            bus.abort = 1'b1;
            step();
            bus.abort = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
